cram_arbiter: RTL

Two-port arbiter that shares the single-ported `cram` instance between the control unit (master 0) and the debugger/loader (master 1). It accepts one word transaction at a time from each requester. It sequences the RAM `oe`/`we`/address/data lines with a fixed multi-cycle access and returns read data with a one-cycle acknowledge pulse. Priority between the masters rotates round-robin, so neither master can starve the other.

---
 rtl/cram_arbiter_if.sv | 58 +++++
 rtl/cram_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cram_arbiter_if.sv
// ---------------------------------------------------------------------------
// cram_arbiter_if
// Bundles the signals between the cram arbiter, its two masters and the
// single-ported cram instance.
//   master 0 (control unit)  : i_w_m0_req/we/addr/wdata  -> o_r_m0_ack/rdata
//   master 1 (debug/loader)  : i_w_m1_req/we/addr/wdata  -> o_r_m1_ack/rdata
//   RAM side                 : o_r_ram_oe/we/addr/in, i_w_ram_out
//   status                   : o_r_grant (one-hot owner), o_w_busy
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requests and models the RAM.
// ---------------------------------------------------------------------------
interface cram_arbiter_if #(
    parameter int p_data_width    = 16,
    parameter int p_address_width = 10
);
    logic                       i_w_m0_req;
    logic                       i_w_m0_we;
    logic [p_address_width-1:0] i_w_m0_addr;
    logic [p_data_width-1:0]    i_w_m0_wdata;
    logic                       o_r_m0_ack;
    logic [p_data_width-1:0]    o_r_m0_rdata;

    logic                       i_w_m1_req;
    logic                       i_w_m1_we;
    logic [p_address_width-1:0] i_w_m1_addr;
    logic [p_data_width-1:0]    i_w_m1_wdata;
    logic                       o_r_m1_ack;
    logic [p_data_width-1:0]    o_r_m1_rdata;

    logic                       o_r_ram_oe;
    logic                       o_r_ram_we;
    logic [p_address_width-1:0] o_r_ram_addr;
    logic [p_data_width-1:0]    o_r_ram_in;
    logic [p_data_width-1:0]    i_w_ram_out;

    logic [1:0]                 o_r_grant;
    logic                       o_w_busy;

    modport slave (
        input  i_w_m0_req, i_w_m0_we, i_w_m0_addr, i_w_m0_wdata,
        output o_r_m0_ack, o_r_m0_rdata,
        input  i_w_m1_req, i_w_m1_we, i_w_m1_addr, i_w_m1_wdata,
        output o_r_m1_ack, o_r_m1_rdata,
        output o_r_ram_oe, o_r_ram_we, o_r_ram_addr, o_r_ram_in,
        input  i_w_ram_out,
        output o_r_grant, o_w_busy
    );

    modport master (
        output i_w_m0_req, i_w_m0_we, i_w_m0_addr, i_w_m0_wdata,
        input  o_r_m0_ack, o_r_m0_rdata,
        output i_w_m1_req, i_w_m1_we, i_w_m1_addr, i_w_m1_wdata,
        input  o_r_m1_ack, o_r_m1_rdata,
        input  o_r_ram_oe, o_r_ram_we, o_r_ram_addr, o_r_ram_in,
        output i_w_ram_out,
        input  o_r_grant, o_w_busy
    );
endinterface

// File: rtl/cram_arbiter.sv
// ---------------------------------------------------------------------------
// cram_arbiter
// Shares one single-ported cram between the control unit (m0) and the
// debugger/loader (m1). Each transaction takes a fixed 4-cycle path
// IDLE -> ACCESS -> WAIT -> RESP; the owner gets a one-cycle ack in RESP.
// Ties are broken round-robin against the last granted master.
// Ports:
//   i_w_clk   : system clock, rising edge
//   i_w_reset : asynchronous active-high reset
//   bus       : cram_arbiter_if.slave (master handshakes, RAM strobes, status)
// ---------------------------------------------------------------------------
module cram_arbiter #(
    parameter int p_data_width    = 16,
    parameter int p_address_width = 10
) (
    input logic          i_w_clk,
    input logic          i_w_reset,
    cram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                     state_q,     state_d;
    logic [1:0]                 grant_q,     grant_d;
    logic                       ram_oe_q,    ram_oe_d;
    logic                       ram_we_q,    ram_we_d;
    logic                       op_we_q,     op_we_d;
    logic [p_address_width-1:0] ram_addr_q,  ram_addr_d;
    logic [p_data_width-1:0]    ram_in_q,    ram_in_d;
    logic                       m0_ack_q,    m0_ack_d;
    logic                       m1_ack_q,    m1_ack_d;
    logic [p_data_width-1:0]    m0_rdata_q,  m0_rdata_d;
    logic [p_data_width-1:0]    m1_rdata_q,  m1_rdata_d;
    logic                       last_m1_q,   last_m1_d;
    logic                       pick_m1;
    logic                       sel_we;

    // Next-state logic. The direction of the captured transaction is kept in
    // op_we because the RAM strobes are already dropped by the time WAIT
    // decides whether to latch read data.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ram_oe_d   = ram_oe_q;
        ram_we_d   = ram_we_q;
        op_we_d    = op_we_q;
        ram_addr_d = ram_addr_q;
        ram_in_d   = ram_in_q;
        m0_ack_d   = m0_ack_q;
        m1_ack_d   = m1_ack_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        last_m1_d  = last_m1_q;
        pick_m1    = 1'b0;
        sel_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_w_m0_req || bus.i_w_m1_req) begin
                    // m1 wins when it is alone, or on a tie when m0 went last.
                    pick_m1 = bus.i_w_m1_req && (!bus.i_w_m0_req || !last_m1_q);
                    if (pick_m1) begin
                        sel_we     = bus.i_w_m1_we;
                        ram_addr_d = bus.i_w_m1_addr;
                        ram_in_d   = bus.i_w_m1_wdata;
                        grant_d    = 2'b10;
                    end else begin
                        sel_we     = bus.i_w_m0_we;
                        ram_addr_d = bus.i_w_m0_addr;
                        ram_in_d   = bus.i_w_m0_wdata;
                        grant_d    = 2'b01;
                    end
                    ram_we_d = sel_we;
                    ram_oe_d = !sel_we;
                    op_we_d  = sel_we;
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                ram_we_d = 1'b0;
                ram_oe_d = 1'b0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (grant_q[1]) begin
                    m1_ack_d = 1'b1;
                    if (!op_we_q) m1_rdata_d = bus.i_w_ram_out;
                end else begin
                    m0_ack_d = 1'b1;
                    if (!op_we_q) m0_rdata_d = bus.i_w_ram_out;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                m0_ack_d  = 1'b0;
                m1_ack_d  = 1'b0;
                last_m1_d = grant_q[1];
                grant_d   = 2'b00;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register. The pointer resets to m1 so that m0 wins the first tie.
    always_ff @(posedge i_w_clk or posedge i_w_reset) begin
        if (i_w_reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= 2'b00;
            ram_oe_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            op_we_q    <= 1'b0;
            ram_addr_q <= '0;
            ram_in_q   <= '0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            last_m1_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ram_oe_q   <= ram_oe_d;
            ram_we_q   <= ram_we_d;
            op_we_q    <= op_we_d;
            ram_addr_q <= ram_addr_d;
            ram_in_q   <= ram_in_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            last_m1_q  <= last_m1_d;
        end
    end

    assign bus.o_r_grant    = grant_q;
    assign bus.o_r_ram_oe   = ram_oe_q;
    assign bus.o_r_ram_we   = ram_we_q;
    assign bus.o_r_ram_addr = ram_addr_q;
    assign bus.o_r_ram_in   = ram_in_q;
    assign bus.o_r_m0_ack   = m0_ack_q;
    assign bus.o_r_m1_ack   = m1_ack_q;
    assign bus.o_r_m0_rdata = m0_rdata_q;
    assign bus.o_r_m1_rdata = m1_rdata_q;
    assign bus.o_w_busy     = (state_q != ST_IDLE);
endmodule
